// File: rtl/xge_wb_pkg.sv
// Shared definitions for the Wishbone interrupt register file.
//   - Byte offsets of every mapped register.
//   - Bus handshake state encoding.
//   - Width of the wait-state down-counter (covers WAIT_STATES up to 15).
package xge_wb_pkg;

    localparam int REG_CONFIG  = 32'h00;
    localparam int REG_PENDING = 32'h04;
    localparam int REG_RAW     = 32'h08;
    localparam int REG_MASK    = 32'h0C;
    localparam int REG_FORCE   = 32'h10;
    localparam int REG_VERSION = 32'h14;

    localparam int WAIT_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/irq_pending_bank.sv
// Interrupt pending/mask bank.
//   clk, rst  : clock, synchronous active-high reset
//   irq_src   : level sources, already synchronous to clk
//   wr_data   : write data for MASK / FORCE
//   mask_we   : load MASK from wr_data at this edge
//   force_we  : OR wr_data into pending at this edge
//   pend_clr  : clear-on-read of pending at this edge
//   pending   : sticky pending bits
//   mask      : interrupt enable bits
//   irq       : registered |(pending & mask)
module irq_pending_bank #(
    parameter int N_SRC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [N_SRC-1:0] wr_data,
    input  logic             mask_we,
    input  logic             force_we,
    input  logic             pend_clr,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] mask,
    output logic             irq
);

    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] set_bits;

    // Rising edges and software force both set; a set landing on the
    // same edge as a clear-on-read survives so no event is lost.
    always_comb begin
        set_bits = irq_src & ~src_q;
        if (force_we)
            set_bits = set_bits | wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q   <= '0;
            pending <= '0;
            mask    <= '0;
            irq     <= 1'b0;
        end else begin
            src_q   <= irq_src;
            pending <= (pend_clr ? '0 : pending) | set_bits;
            if (mask_we)
                mask <= wr_data;
            irq     <= |(pending & mask);
        end
    end

endmodule

// File: rtl/wb_irq_regfile.sv
// Wishbone classic slave: CONFIG register plus an N_SRC-channel interrupt
// controller with programmable wait states.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   wb_adr_i           : byte address (word offset = wb_adr_i[ADR_W-1:2])
//   wb_cyc_i, wb_stb_i : bus cycle / strobe
//   wb_we_i, wb_dat_i  : write enable / write data
//   wb_dat_o, wb_ack_o : read data (0 outside ack) / one-cycle acknowledge
//   wb_int_o           : registered |(pending & mask)
//   irq_src_i          : level interrupt sources
//   cfg_o              : CONFIG register contents
module wb_irq_regfile
    import xge_wb_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          ADR_W       = 8,
    parameter int          N_SRC       = 16,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] VERSION     = 32'h0001_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [ADR_W-1:0]  wb_adr_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_int_o,
    input  logic [N_SRC-1:0]  irq_src_i,
    output logic [DATA_W-1:0] cfg_o
);

    localparam int IDX_W = ADR_W - 2;
    localparam logic [IDX_W-1:0] IDX_CONFIG  = IDX_W'(REG_CONFIG  / 4);
    localparam logic [IDX_W-1:0] IDX_PENDING = IDX_W'(REG_PENDING / 4);
    localparam logic [IDX_W-1:0] IDX_RAW     = IDX_W'(REG_RAW     / 4);
    localparam logic [IDX_W-1:0] IDX_MASK    = IDX_W'(REG_MASK    / 4);
    localparam logic [IDX_W-1:0] IDX_VERSION = IDX_W'(REG_VERSION / 4);
    localparam logic [IDX_W-1:0] IDX_FORCE   = IDX_W'(REG_FORCE   / 4);

    wb_state_e             state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [IDX_W-1:0]      adr_q;
    logic                  we_q;
    logic [DATA_W-1:0]     dat_q;
    logic [DATA_W-1:0]     cfg;
    logic [DATA_W-1:0]     rd_mux;
    logic [DATA_W-1:0]     pend_ext, mask_ext, raw_ext;
    logic [N_SRC-1:0]      pending, mask;
    logic [IDX_W-1:0]      adr_idx;
    logic                  req, go_ack, in_ack;
    logic                  wr_cfg, wr_mask, wr_force, pend_clr;
    logic                  unused_adr_lo;

    assign adr_idx       = wb_adr_i[ADR_W-1:2];
    assign unused_adr_lo = ^wb_adr_i[1:0];
    assign req           = wb_cyc_i & wb_stb_i;
    assign in_ack        = (state == ACK);
    assign cfg_o         = cfg;

    // Cycle in which the ack is scheduled: the next edge enters ACK.
    always_comb begin
        go_ack = 1'b0;
        if (state == IDLE && req && WAIT_STATES == 0)
            go_ack = 1'b1;
        else if (state == WAIT && req && wait_cnt == '0)
            go_ack = 1'b1;
    end

    // Side effects happen at the edge ending ACK, using the address/data
    // captured on entry so a master changing signals late cannot corrupt them.
    assign wr_cfg   = in_ack &  we_q & (adr_q == IDX_CONFIG);
    assign wr_mask  = in_ack &  we_q & (adr_q == IDX_MASK);
    assign wr_force = in_ack &  we_q & (adr_q == IDX_FORCE);
    assign pend_clr = in_ack & ~we_q & (adr_q == IDX_PENDING);

    always_comb begin
        pend_ext = '0;
        mask_ext = '0;
        raw_ext  = '0;
        pend_ext[N_SRC-1:0] = pending;
        mask_ext[N_SRC-1:0] = mask;
        raw_ext[N_SRC-1:0]  = irq_src_i;
        rd_mux   = '0;
        case (adr_idx)
            IDX_CONFIG:  rd_mux = cfg;
            IDX_PENDING: rd_mux = pend_ext;
            IDX_RAW:     rd_mux = raw_ext;
            IDX_MASK:    rd_mux = mask_ext;
            IDX_VERSION: rd_mux = DATA_W'(VERSION);
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            wait_cnt <= '0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            adr_q    <= '0;
            we_q     <= 1'b0;
            dat_q    <= '0;
            cfg      <= '0;
        end else begin
            wb_ack_o <= go_ack;
            wb_dat_o <= go_ack ? rd_mux : '0;
            if (go_ack) begin
                adr_q <= adr_idx;
                we_q  <= wb_we_i;
                dat_q <= wb_dat_i;
            end
            case (state)
                IDLE: if (req) begin
                    state    <= (WAIT_STATES == 0) ? ACK : WAIT;
                    wait_cnt <= WAIT_CNT_W'(WAIT_STATES - 1);
                end
                WAIT: begin
                    if (!req)
                        state <= IDLE;
                    else if (wait_cnt == '0)
                        state <= ACK;
                    else
                        wait_cnt <= wait_cnt - 1'b1;
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
            if (wr_cfg)
                cfg <= dat_q;
        end
    end

    irq_pending_bank #(.N_SRC(N_SRC)) u_bank (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .irq_src  (irq_src_i),
        .wr_data  (dat_q[N_SRC-1:0]),
        .mask_we  (wr_mask),
        .force_we (wr_force),
        .pend_clr (pend_clr),
        .pending  (pending),
        .mask     (mask),
        .irq      (wb_int_o)
    );

endmodule

// File: tb/tb_wb_irq_regfile.sv
module tb_wb_irq_regfile;

    localparam int WS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  adr = '0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        ack, int_o;
    logic [15:0] irq = '0;
    logic [31:0] cfg_o;

    int tests = 0;
    int fails = 0;
    bit irq_rand = 1'b0;

    // Reference model state
    logic [31:0] m_cfg  = '0;
    logic [15:0] m_pend = '0, m_mask = '0, m_prev = '0;
    logic        m_int  = 1'b0;
    logic [15:0] m_set;
    logic        m_clr;
    // Completed transfer handed to the model for the edge ending its ack
    logic        c_valid = 1'b0, c_we = 1'b0;
    logic [7:0]  c_adr = '0;
    logic [31:0] c_dat = '0;

    wb_irq_regfile #(
        .DATA_W(32), .ADR_W(8), .N_SRC(16), .WAIT_STATES(WS), .VERSION(32'h0001_0000)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_we_i(we), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_int_o(int_o),
        .irq_src_i(irq), .cfg_o(cfg_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Model: a pending bit is set by a rising source or a FORCE write; a
    // completed PENDING read empties the register, but sets on that edge stay.
    always_comb begin
        m_set = irq & ~m_prev;
        if (c_valid && c_we && (c_adr & 8'hFC) == 8'h10) m_set = m_set | c_dat[15:0];
        m_clr = c_valid && !c_we && (c_adr & 8'hFC) == 8'h04;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_cfg <= '0; m_pend <= '0; m_mask <= '0; m_prev <= '0; m_int <= 1'b0;
        end else begin
            m_prev <= irq;
            m_pend <= (m_clr ? 16'h0 : m_pend) | m_set;
            m_int  <= |(m_pend & m_mask);
            if (c_valid && c_we && (c_adr & 8'hFC) == 8'h00) m_cfg  <= c_dat;
            if (c_valid && c_we && (c_adr & 8'hFC) == 8'h0C) m_mask <= c_dat[15:0];
        end
    end

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a & 8'hFC)
            8'h00:   return m_cfg;
            8'h04:   return {16'h0, m_pend};
            8'h08:   return {16'h0, irq};
            8'h0C:   return {16'h0, m_mask};
            8'h14:   return 32'h0001_0000;
            default: return 32'h0;
        endcase
    endfunction

    // One Wishbone access; lat = cycles from first strobe cycle to ack, -1 if none.
    // race bits are raised on irq in the cycle the ack is due.
    task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [15:0] race, output logic [31:0] rd,
                       output logic [31:0] exp_rd, output int lat);
        logic [31:0] snap;
        snap = '0; rd = '0; exp_rd = '0; lat = -1;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
        for (int k = 0; k < 20; k++) begin
            if (irq_rand && k > 0) irq = 16'($urandom);
            if (k == WS + 1) irq = irq | race;
            @(negedge clk);
            if (ack) begin
                lat = k; rd = dat_o; exp_rd = snap;
                c_we = w; c_adr = a; c_dat = d; c_valid = 1'b1;
                break;
            end
            snap = model_read(a);
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        c_valid = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] rd, ex; int lat;
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests++; if (ack !== 1'b0)       begin fails++; $display("FAIL reset_ack got %b want 0", ack); end
        tests++; if (dat_o !== 32'h0)    begin fails++; $display("FAIL reset_dat got %h want 0", dat_o); end
        tests++; if (int_o !== 1'b0)     begin fails++; $display("FAIL reset_int got %b want 0", int_o); end
        tests++; if (cfg_o !== 32'h0)    begin fails++; $display("FAIL reset_cfg got %h want 0", cfg_o); end
        bus(1'b0, 8'h14, 0, 0, rd, ex, lat);
        tests++; if (rd !== 32'h0001_0000) begin fails++; $display("FAIL reset_version got %h want 00010000", rd); end
        tests++; if (lat != WS + 1)        begin fails++; $display("FAIL reset_lat got %0d want %0d", lat, WS + 1); end
        for (int i = 0; i < 3; i++) begin
            logic [7:0] a;
            a = (i == 0) ? 8'h00 : (i == 1) ? 8'h0C : 8'h04;
            bus(1'b0, a, 0, 0, rd, ex, lat);
            tests++; if (rd !== 32'h0) begin fails++; $display("FAIL reset_reg_%h got %h want 0", a, rd); end
        end
    endtask

    task automatic test_wait_states;
        logic [31:0] rd, ex; int lat;
        bus(1'b1, 8'h00, 32'hA5A5_0001, 0, rd, ex, lat);
        tests++; if (lat != 4) begin fails++; $display("FAIL ws_ack_latency got %0d want 4", lat); end
        @(negedge clk);
        tests++; if (cfg_o !== 32'hA5A5_0001) begin fails++; $display("FAIL ws_cfg_o got %h want a5a50001", cfg_o); end
        bus(1'b0, 8'h00, 0, 0, rd, ex, lat);
        tests++; if (rd !== 32'hA5A5_0001) begin fails++; $display("FAIL ws_readback got %h want a5a50001", rd); end
    endtask

    task automatic test_interrupt;
        logic [31:0] rd, ex; int lat;
        bus(1'b1, 8'h0C, 32'h4, 0, rd, ex, lat);
        @(posedge clk); #1 irq[2] = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 irq[2] = 1'b0;
        @(negedge clk);
        tests++; if (int_o !== 1'b0) begin fails++; $display("FAIL irq_int_early got %b want 0", int_o); end
        @(negedge clk);
        tests++; if (int_o !== 1'b1) begin fails++; $display("FAIL irq_int_2cyc got %b want 1", int_o); end
        bus(1'b0, 8'h04, 0, 0, rd, ex, lat);
        tests++; if (rd !== 32'h4) begin fails++; $display("FAIL irq_pending got %h want 4", rd); end
        bus(1'b0, 8'h04, 0, 0, rd, ex, lat);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL irq_pending_cleared got %h want 0", rd); end
        @(negedge clk);
        tests++; if (int_o !== 1'b0) begin fails++; $display("FAIL irq_int_fall got %b want 0", int_o); end
    endtask

    task automatic test_race;
        logic [31:0] rd, ex; int lat;
        bus(1'b1, 8'h10, 32'h2, 0, rd, ex, lat);
        bus(1'b0, 8'h04, 0, 16'h0020, rd, ex, lat);
        tests++; if (rd !== 32'h2)  begin fails++; $display("FAIL race_old_value got %h want 2", rd); end
        bus(1'b0, 8'h04, 0, 0, rd, ex, lat);
        tests++; if (rd !== 32'h20) begin fails++; $display("FAIL race_bit5_kept got %h want 20", rd); end
        irq = '0;
    endtask

    task automatic test_abort;
        logic [31:0] rd, ex; int lat; int acks;
        bus(1'b1, 8'h0C, 32'h0, 0, rd, ex, lat);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h0C; dat_i = 32'hFFFF;
        @(posedge clk); #1;
        @(posedge clk); #1 stb = 1'b0; cyc = 1'b0; we = 1'b0;
        acks = 0;
        repeat (8) begin @(negedge clk); if (ack) acks++; end
        tests++; if (acks != 0) begin fails++; $display("FAIL abort_no_ack got %0d acks want 0", acks); end
        bus(1'b0, 8'h0C, 0, 0, rd, ex, lat);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL abort_mask got %h want 0", rd); end
        bus(1'b0, 8'h40, 0, 0, rd, ex, lat);
        tests++; if (lat != WS + 1) begin fails++; $display("FAIL unmapped_ack got %0d want %0d", lat, WS + 1); end
        tests++; if (rd !== 32'h0)  begin fails++; $display("FAIL unmapped_data got %h want 0", rd); end
    endtask

    task automatic test_force;
        logic [31:0] rd, ex; int lat;
        bus(1'b1, 8'h10, 32'h8001, 0, rd, ex, lat);
        repeat (3) begin
            @(negedge clk);
            tests++; if (int_o !== 1'b0) begin fails++; $display("FAIL force_int_masked got %b want 0", int_o); end
        end
        bus(1'b1, 8'h0C, 32'h1, 0, rd, ex, lat);
        @(negedge clk);
        @(negedge clk);
        tests++; if (int_o !== 1'b1) begin fails++; $display("FAIL force_int_unmasked got %b want 1", int_o); end
        bus(1'b0, 8'h04, 0, 0, rd, ex, lat);
        tests++; if (rd !== 32'h8001) begin fails++; $display("FAIL force_pending got %h want 8001", rd); end
    endtask

    task automatic test_back_to_back;
        int ack_at[$]; logic [31:0] dq[$];
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h14;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack) begin ack_at.push_back(k); dq.push_back(dat_o); end
            @(posedge clk); #1;
            if (ack_at.size() == 2) break;
        end
        cyc = 1'b0; stb = 1'b0;
        tests++;
        if (ack_at.size() != 2) begin
            fails++; $display("FAIL b2b_ack_count got %0d want 2", ack_at.size());
        end else begin
            if (ack_at[0] != WS + 1 || ack_at[1] != 2 * WS + 3) begin
                fails++; $display("FAIL b2b_ack_cycles got %0d,%0d want %0d,%0d",
                                  ack_at[0], ack_at[1], WS + 1, 2 * WS + 3);
            end
            tests++;
            if (dq[0] !== 32'h0001_0000 || dq[1] !== 32'h0001_0000) begin
                fails++; $display("FAIL b2b_data got %h,%h want 00010000", dq[0], dq[1]);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, ex; int lat;
        logic [7:0] regs[7] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h40};
        irq_rand = 1'b1;
        for (int n = 0; n < 60; n++) begin
            logic [7:0] a; logic w;
            a = regs[$urandom_range(0, 6)];
            w = 1'($urandom);
            bus(w, a, $urandom, 0, rd, ex, lat);
            tests++; if (lat != WS + 1) begin fails++; $display("FAIL rand_lat[%0d] got %0d want %0d", n, lat, WS + 1); end
            if (!w) begin
                tests++;
                if (rd !== ex) begin fails++; $display("FAIL rand_read[%0d] adr %h got %h want %h", n, a, rd, ex); end
            end
            @(negedge clk);
            tests++; if (int_o !== m_int) begin fails++; $display("FAIL rand_int[%0d] got %b want %b", n, int_o, m_int); end
            tests++; if (cfg_o !== m_cfg) begin fails++; $display("FAIL rand_cfg[%0d] got %h want %h", n, cfg_o, m_cfg); end
        end
        irq_rand = 1'b0;
        irq = '0;
    endtask

    initial begin
        test_reset;
        test_wait_states;
        test_interrupt;
        test_race;
        test_abort;
        test_force;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
